rhythm_judge: RTL and testbench
===============================

# rhythm_judge

Parametrised multi-lane note engine and judge for the falling-note game. It owns one note per lane and advances each note's y position on a frame tick. It synchronises and edge-detects the lane keys and judges each press against a hit window. It accumulates score, streak and lives, and exposes per-lane positions to the lane renderers and the score to the HEX decoder.

## Interface
- LANES, 4, number of lanes (1..8)
- Y_W, 8, note y-position width
- STEP, 2, y increment per tick
- HIT_LO, 106, lowest y inside the hit window
- HIT_HI, 134, highest y inside the hit window
- MISS_Y, 136, y at or beyond which a falling note is a miss; legal only if HIT_LO ≤ HIT_HI < MISS_Y and MISS_Y+STEP ≤ 2^Y_W−1
- SCORE_W, 8, score and streak width
- LIVES_INIT, 3, lives after reset (≤15)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock, sampled on rising clk
- tick  in  1  one-cycle frame pulse
- spawn  in  LANES  per-lane request to launch a note
- key_n  in  LANES  raw board keys, active-low, asynchronous
- note_y  out  LANES*Y_W  lane i at bits [i*Y_W +: Y_W]
- note_active  out  LANES  lane holds a falling note
- hit  out  LANES  one-cycle pulse per judged hit
- miss  out  LANES  one-cycle pulse per missed note
- ghost  out  LANES  one-cycle pulse for a press with no note in the window
- score  out  SCORE_W  saturating hit count
- streak  out  SCORE_W  consecutive hits since last miss, saturating
- lives  out  4  remaining lives
- game_over  out  1  high once lives reach 0

## Operation
- Reset sets every output to 0 except lives, which is set to LIVES_INIT. Reset also puts every lane in IDLE and clears both sync flops to "released" (1).
- Key path per lane:
  - two-flop synchroniser on key_n
  - press = previous synced 1 and current synced 0
  - holding a key yields exactly one press
- Lane FSM, states IDLE and FALL:
  - IDLE + spawn: go to FALL with y=0. tick in the same cycle is ignored.
  - FALL + spawn: spawn is ignored.
  - FALL + tick: y ← y+STEP.
  - FALL + press with HIT_LO ≤ y ≤ HIT_HI: hit pulse, go to IDLE, y ← 0. A tick in the same cycle is discarded.
  - FALL with y ≥ MISS_Y: miss pulse, go to IDLE, y ← 0. Evaluated every cycle, not only on tick.
  - Any press that is not a hit (IDLE, or FALL outside the window): ghost pulse, no other effect.
- Scoring, aggregated across lanes in one cycle:
  - score += popcount(hit), saturating at 2^SCORE_W−1
  - if any miss: streak ← 0, even if a hit occurs in the same cycle
  - else streak += popcount(hit), saturating
  - lives −= popcount(miss), saturating at 0
- game_over is set when lives becomes 0 and is sticky until reset. While game_over is high:
  - spawn and tick are ignored
  - presses produce no hit or ghost
  - notes freeze in place
  - score and streak hold

## Timing
- Judgement and pulses:
  - press is valid 2 clk after a key_n falling edge settles
  - the hit/ghost pulse is registered 1 clk after press
  - key_n edge to hit is therefore 3 clk
- Counter updates: score/streak/lives update on the same edge that asserts hit/miss, so they are visible in the pulse cycle.
- Lane position:
  - spawn at edge t gives note_active=1, y=0 after edge t
  - tick at edge t gives the new y after edge t
- Miss timing: miss asserts the cycle after y first reaches ≥ MISS_Y. note_active drops in the same cycle.
- The cycle lives reaches 0 is the cycle game_over rises.
- reset mid-note: all lanes return to IDLE on the next edge, and no miss is emitted.

## Structure
- rhythm_pkg holds:
  - lane state encoding (IDLE, FALL)
  - default parameter constants
  - a saturating-add helper function
- One sub-module, rhythm_lane, holds the synchroniser, edge detect, FSM and y register. It is instantiated LANES times in a generate loop.
- Top level holds the popcount, score/streak/lives registers and the game_over latch.

## Test plan
- Lane 0 spawn, 54 ticks (y=108), then key_n[0] low for 10 clk → exactly one hit[0] 3 clk after the edge; score=1, streak=1, note_active[0]=0.
- Lane 1 spawn, 68 ticks (y=136), no key → miss[1] next clk; lives 3→2, streak→0, y cleared.
- Lane 2 idle: key press → ghost[2] only, score and lives unchanged. Spawn then press at y=20 → ghost[2], note keeps falling.
- Lanes 0 and 3 hit in the same cycle → score +2, streak +2. Lanes 0 and 1 miss in the same cycle with lives=1 → lives=0, game_over=1; later spawn/tick/press have no effect.
- SCORE_W=2: four hits → score saturates at 3. Spawn and tick in the same cycle on an IDLE lane → y=0 next cycle.
- Assert reset with notes at y=50 in all lanes → next cycle all outputs 0, lives=3, no miss pulses.

Source files
------------

// File: rtl/rhythm_pkg.sv
// rhythm_pkg: lane state encoding, default parameters and saturating-add helper shared by the rhythm_judge slice
package rhythm_pkg;
  typedef enum logic {IDLE, FALL} lane_st_e;
  localparam int LANES_D = 4;
  localparam int Y_W_D = 8;
  localparam int STEP_D = 2;
  localparam int HIT_LO_D = 106;
  localparam int HIT_HI_D = 134;
  localparam int MISS_Y_D = 136;
  localparam int SCORE_W_D = 8;
  localparam int LIVES_INIT_D = 3;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s > {1'b0, max} ? max : s[31:0];
  endfunction
endpackage

// File: rtl/rhythm_judge_if.sv
// rhythm_judge_if: game bus; master drives tick/spawn/key_n, slave returns note_y/note_active/hit/miss/ghost/score/streak/lives/game_over
interface rhythm_judge_if import rhythm_pkg::*; #(
  parameter int LANES = LANES_D,
  parameter int Y_W = Y_W_D,
  parameter int SCORE_W = SCORE_W_D
);
  logic tick;
  logic [LANES-1:0] spawn;
  logic [LANES-1:0] key_n;
  logic [LANES*Y_W-1:0] note_y;
  logic [LANES-1:0] note_active;
  logic [LANES-1:0] hit;
  logic [LANES-1:0] miss;
  logic [LANES-1:0] ghost;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] streak;
  logic [3:0] lives;
  logic game_over;
  modport master(output tick, spawn, key_n, input note_y, note_active, hit, miss, ghost, score, streak, lives, game_over);
  modport slave(input tick, spawn, key_n, output note_y, note_active, hit, miss, ghost, score, streak, lives, game_over);
endinterface

// File: rtl/rhythm_lane.sv
// rhythm_lane: one lane's key synchroniser/edge detect, IDLE/FALL FSM and y register; ports clk, reset, freeze_i, tick_i, spawn_i, key_n_i in; y_o, active_o and combinational hit_o/miss_o/ghost_o judgements out
module rhythm_lane import rhythm_pkg::*; #(
  parameter int Y_W = Y_W_D,
  parameter int STEP = STEP_D,
  parameter int HIT_LO = HIT_LO_D,
  parameter int HIT_HI = HIT_HI_D,
  parameter int MISS_Y = MISS_Y_D
) (
  input  logic clk,
  input  logic reset,
  input  logic freeze_i,
  input  logic tick_i,
  input  logic spawn_i,
  input  logic key_n_i,
  output logic [Y_W-1:0] y_o,
  output logic active_o,
  output logic hit_o,
  output logic miss_o,
  output logic ghost_o
);
  lane_st_e st_q, st_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [2:0] ks_q;
  logic press;
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      y_q <= '0;
      ks_q <= '1;
    end else begin
      st_q <= st_d;
      y_q <= y_d;
      ks_q <= {ks_q[1:0], key_n_i};
    end
  end
  always_comb begin
    press = ks_q[2] & ~ks_q[1];
    miss_o = !freeze_i && st_q == FALL && y_q >= Y_W'(MISS_Y);
    hit_o = !freeze_i && st_q == FALL && press && y_q >= Y_W'(HIT_LO) && y_q <= Y_W'(HIT_HI);
    ghost_o = !freeze_i && press && !hit_o;
    st_d = freeze_i ? st_q : st_q == IDLE ? (spawn_i ? FALL : IDLE) : (hit_o || miss_o) ? IDLE : FALL;
    y_d = freeze_i ? y_q : (st_q == IDLE || hit_o || miss_o) ? '0 : tick_i ? y_q + Y_W'(STEP) : y_q;
    y_o = y_q;
    active_o = st_q == FALL;
  end
endmodule

// File: rtl/rhythm_judge.sv
// rhythm_judge: multi-lane note engine and judge; ports clk, reset plus slave bus (tick/spawn/key_n in; note_y/note_active/hit/miss/ghost/score/streak/lives/game_over out)
module rhythm_judge import rhythm_pkg::*; #(
  parameter int LANES = LANES_D,
  parameter int Y_W = Y_W_D,
  parameter int STEP = STEP_D,
  parameter int HIT_LO = HIT_LO_D,
  parameter int HIT_HI = HIT_HI_D,
  parameter int MISS_Y = MISS_Y_D,
  parameter int SCORE_W = SCORE_W_D,
  parameter int LIVES_INIT = LIVES_INIT_D
) (
  input logic clk,
  input logic reset,
  rhythm_judge_if.slave bus
);
  logic [LANES-1:0] hit_d, miss_d, ghost_d, hit_q, miss_q, ghost_q, active_w;
  logic [LANES*Y_W-1:0] y_w;
  logic [SCORE_W-1:0] score_q, score_d, streak_q, streak_d;
  logic [3:0] lives_q, lives_d;
  logic go_q, go_d;
  logic [31:0] nh, nm, smax;
  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      rhythm_lane #(.Y_W(Y_W), .STEP(STEP), .HIT_LO(HIT_LO), .HIT_HI(HIT_HI), .MISS_Y(MISS_Y)) u_lane (
        .clk(clk), .reset(reset), .freeze_i(go_q), .tick_i(bus.tick), .spawn_i(bus.spawn[i]),
        .key_n_i(bus.key_n[i]), .y_o(y_w[i*Y_W +: Y_W]), .active_o(active_w[i]),
        .hit_o(hit_d[i]), .miss_o(miss_d[i]), .ghost_o(ghost_d[i])
      );
    end
  endgenerate
  always_comb begin
    nh = 32'($countones(hit_d));
    nm = 32'($countones(miss_d));
    smax = 32'({SCORE_W{1'b1}});
    score_d = SCORE_W'(sat_add(32'(score_q), nh, smax));
    streak_d = |miss_d ? '0 : SCORE_W'(sat_add(32'(streak_q), nh, smax));
    lives_d = nm >= 32'(lives_q) ? '0 : lives_q - 4'(nm);
    go_d = go_q | (lives_d == 4'd0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q <= '0;
      miss_q <= '0;
      ghost_q <= '0;
      score_q <= '0;
      streak_q <= '0;
      lives_q <= 4'(LIVES_INIT);
      go_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
      miss_q <= miss_d;
      ghost_q <= ghost_d;
      score_q <= score_d;
      streak_q <= streak_d;
      lives_q <= lives_d;
      go_q <= go_d;
    end
  end
  assign bus.note_y = y_w;
  assign bus.note_active = active_w;
  assign bus.hit = hit_q;
  assign bus.miss = miss_q;
  assign bus.ghost = ghost_q;
  assign bus.score = score_q;
  assign bus.streak = streak_q;
  assign bus.lives = lives_q;
  assign bus.game_over = go_q;
endmodule

// File: tb/tb_rhythm_judge.sv
// tb_rhythm_judge: directed scenarios plus randomized run against a behavioural game model, with a second SCORE_W=2 instance for saturation
module tb_rhythm_judge;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rhythm_judge_if #(.LANES(4), .Y_W(8), .SCORE_W(8)) bus();
  rhythm_judge_if #(.LANES(4), .Y_W(8), .SCORE_W(2)) bus2();
  assign bus2.tick = bus.tick;
  assign bus2.spawn = bus.spawn;
  assign bus2.key_n = bus.key_n;
  rhythm_judge dut(.clk(clk), .reset(reset), .bus(bus));
  rhythm_judge #(.SCORE_W(2)) dut2(.clk(clk), .reset(reset), .bus(bus2));
  int my[4];
  bit ma[4], mk1[4], mk2[4], mk3[4];
  logic [3:0] mh, mm, mg;
  int ms, mst, ms2, mst2, ml;
  bit mgo;
  function automatic int mn(int a, int b);
    return a < b ? a : b;
  endfunction
  function automatic logic [7:0] ny(int l);
    return bus.note_y[l*8 +: 8];
  endfunction
  task automatic cyc();
    int nh, nm, h, m, p;
    @(posedge clk);
    nh = 0;
    nm = 0;
    mh = '0;
    mm = '0;
    mg = '0;
    for (int l = 0; l < 4; l++) begin
      if (reset) begin
        ma[l] = 0; my[l] = 0; mk1[l] = 1; mk2[l] = 1; mk3[l] = 1;
      end else begin
        p = int'(mk3[l] && !mk2[l]);
        if (!mgo) begin
          h = int'(ma[l] && p != 0 && my[l] >= 106 && my[l] <= 134);
          m = int'(ma[l] && my[l] >= 136);
          mh[l] = h[0]; mm[l] = m[0]; mg[l] = p != 0 && h == 0;
          nh += h; nm += m;
          if (!ma[l]) begin ma[l] = bus.spawn[l]; my[l] = 0; end
          else if (h != 0 || m != 0) begin ma[l] = 0; my[l] = 0; end
          else if (bus.tick) my[l] += 2;
        end
        mk3[l] = mk2[l]; mk2[l] = mk1[l]; mk1[l] = bus.key_n[l];
      end
    end
    if (reset) begin
      ms = 0; mst = 0; ms2 = 0; mst2 = 0; ml = 3; mgo = 0;
    end else begin
      ms = mn(ms + nh, 255); ms2 = mn(ms2 + nh, 3);
      mst = nm != 0 ? 0 : mn(mst + nh, 255); mst2 = nm != 0 ? 0 : mn(mst2 + nh, 3);
      ml = ml - nm < 0 ? 0 : ml - nm;
      mgo = mgo || ml == 0;
    end
    #1;
  endtask
  task automatic do_reset();
    reset = 1; bus.spawn = '0; bus.tick = 0; bus.key_n = '1;
    cyc();
    reset = 0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (bus.score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d want 0", bus.score); end
    checks++; if (bus.streak !== 8'd0) begin errors++; $display("FAIL reset_streak got %0d want 0", bus.streak); end
    checks++; if (bus.lives !== 4'd3) begin errors++; $display("FAIL reset_lives got %0d want 3", bus.lives); end
    checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL reset_go got %0d want 0", bus.game_over); end
    checks++; if ({bus.note_active, bus.hit, bus.miss, bus.ghost} !== 16'd0) begin errors++; $display("FAIL reset_flags got %h want 0", {bus.note_active, bus.hit, bus.miss, bus.ghost}); end
    checks++; if (bus.note_y !== 32'd0) begin errors++; $display("FAIL reset_y got %h want 0", bus.note_y); end
  endtask
  task automatic test_hit();
    int hc = 0, hat = 0;
    do_reset();
    bus.spawn = 4'b0001; cyc(); bus.spawn = '0;
    bus.tick = 1; repeat (54) cyc(); bus.tick = 0;
    checks++; if (ny(0) !== 8'd108) begin errors++; $display("FAIL hit_y got %0d want 108", ny(0)); end
    bus.key_n[0] = 0;
    for (int c = 1; c <= 10; c++) begin cyc(); if (bus.hit[0]) begin hc++; hat = c; end end
    checks++; if (hc !== 1) begin errors++; $display("FAIL hit_count got %0d want 1", hc); end
    checks++; if (hat !== 3) begin errors++; $display("FAIL hit_latency got %0d want 3", hat); end
    checks++; if (bus.score !== 8'd1 || bus.streak !== 8'd1) begin errors++; $display("FAIL hit_score got %0d/%0d want 1/1", bus.score, bus.streak); end
    checks++; if (bus.note_active[0] !== 1'b0) begin errors++; $display("FAIL hit_active got %0d want 0", bus.note_active[0]); end
    bus.key_n[0] = 1; repeat (4) cyc();
  endtask
  task automatic test_miss();
    do_reset();
    bus.spawn = 4'b0010; cyc(); bus.spawn = '0;
    bus.tick = 1; repeat (68) cyc(); bus.tick = 0;
    checks++; if (ny(1) !== 8'd136 || bus.miss !== 4'd0) begin errors++; $display("FAIL miss_pre got y=%0d miss=%b want 136/0000", ny(1), bus.miss); end
    cyc();
    checks++; if (bus.miss !== 4'b0010) begin errors++; $display("FAIL miss_pulse got %b want 0010", bus.miss); end
    checks++; if (bus.lives !== 4'd2 || bus.streak !== 8'd0) begin errors++; $display("FAIL miss_lives got %0d/%0d want 2/0", bus.lives, bus.streak); end
    checks++; if (ny(1) !== 8'd0 || bus.note_active[1] !== 1'b0) begin errors++; $display("FAIL miss_clear got %0d/%0d want 0/0", ny(1), bus.note_active[1]); end
  endtask
  task automatic test_ghost();
    int gc = 0, hc = 0;
    do_reset();
    bus.key_n[2] = 0;
    repeat (6) begin cyc(); gc += int'(bus.ghost[2]); hc += int'($countones(bus.hit | bus.ghost & 4'b1011)); end
    checks++; if (gc !== 1 || hc !== 0) begin errors++; $display("FAIL ghost_idle got %0d/%0d want 1/0", gc, hc); end
    checks++; if (bus.score !== 8'd0 || bus.lives !== 4'd3) begin errors++; $display("FAIL ghost_counters got %0d/%0d want 0/3", bus.score, bus.lives); end
    bus.key_n[2] = 1; repeat (3) cyc();
    bus.spawn = 4'b0100; cyc(); bus.spawn = '0;
    bus.tick = 1; repeat (10) cyc(); bus.tick = 0;
    bus.key_n[2] = 0; gc = 0;
    repeat (6) begin cyc(); gc += int'(bus.ghost[2]); end
    checks++; if (gc !== 1) begin errors++; $display("FAIL ghost_fall got %0d want 1", gc); end
    checks++; if (bus.note_active[2] !== 1'b1 || ny(2) !== 8'd20) begin errors++; $display("FAIL ghost_keep got %0d/%0d want 1/20", bus.note_active[2], ny(2)); end
    bus.key_n[2] = 1; repeat (3) cyc();
  endtask
  task automatic test_double_hit();
    logic [3:0] hv = '0;
    do_reset();
    bus.spawn = 4'b1001; cyc(); bus.spawn = '0;
    bus.tick = 1; repeat (54) cyc(); bus.tick = 0;
    bus.key_n = 4'b0110;
    for (int c = 1; c <= 5; c++) begin cyc(); if (c == 3) hv = bus.hit; end
    checks++; if (hv !== 4'b1001) begin errors++; $display("FAIL double_hit got %b want 1001", hv); end
    checks++; if (bus.score !== 8'd2 || bus.streak !== 8'd2) begin errors++; $display("FAIL double_score got %0d/%0d want 2/2", bus.score, bus.streak); end
    bus.key_n = '1; repeat (3) cyc();
  endtask
  task automatic test_game_over();
    logic [3:0] any = '0;
    do_reset();
    repeat (2) begin
      bus.spawn = 4'b0100; cyc(); bus.spawn = '0;
      bus.tick = 1; repeat (68) cyc(); bus.tick = 0; cyc();
    end
    checks++; if (bus.lives !== 4'd1) begin errors++; $display("FAIL go_lives1 got %0d want 1", bus.lives); end
    bus.spawn = 4'b0011; cyc();
    bus.spawn = '0; bus.tick = 1; repeat (10) cyc();
    bus.spawn = 4'b1000; cyc();
    bus.spawn = '0; repeat (57) cyc();
    bus.tick = 0; cyc();
    checks++; if (bus.miss !== 4'b0011) begin errors++; $display("FAIL go_miss got %b want 0011", bus.miss); end
    checks++; if (bus.lives !== 4'd0 || bus.game_over !== 1'b1) begin errors++; $display("FAIL go_rise got %0d/%0d want 0/1", bus.lives, bus.game_over); end
    checks++; if (ny(3) !== 8'd114) begin errors++; $display("FAIL go_y3 got %0d want 114", ny(3)); end
    bus.tick = 1; bus.spawn = '1; bus.key_n = 4'b0111;
    repeat (20) begin cyc(); any |= bus.hit | bus.ghost | bus.miss; end
    checks++; if (any !== 4'd0) begin errors++; $display("FAIL go_pulses got %b want 0000", any); end
    checks++; if (ny(3) !== 8'd114 || bus.note_active !== 4'b1000) begin errors++; $display("FAIL go_freeze got %0d/%b want 114/1000", ny(3), bus.note_active); end
    checks++; if (bus.score !== 8'd0 || bus.game_over !== 1'b1) begin errors++; $display("FAIL go_hold got %0d/%0d want 0/1", bus.score, bus.game_over); end
    do_reset();
  endtask
  task automatic test_saturate();
    do_reset();
    bus.spawn = 4'b1111; cyc(); bus.spawn = '0;
    bus.tick = 1; repeat (54) cyc(); bus.tick = 0;
    bus.key_n = '0; repeat (5) cyc();
    checks++; if (bus2.score !== 2'd3 || bus2.streak !== 2'd3) begin errors++; $display("FAIL sat_w2 got %0d/%0d want 3/3", bus2.score, bus2.streak); end
    checks++; if (bus.score !== 8'd4) begin errors++; $display("FAIL sat_w8 got %0d want 4", bus.score); end
    bus.key_n = '1; repeat (3) cyc();
  endtask
  task automatic test_spawn_tick();
    do_reset();
    bus.spawn = 4'b0010; bus.tick = 1; cyc();
    checks++; if (bus.note_active[1] !== 1'b1 || ny(1) !== 8'd0) begin errors++; $display("FAIL spawn_tick got %0d/%0d want 1/0", bus.note_active[1], ny(1)); end
    bus.spawn = '0; cyc(); bus.tick = 0;
    checks++; if (ny(1) !== 8'd2) begin errors++; $display("FAIL spawn_step got %0d want 2", ny(1)); end
  endtask
  task automatic test_reset_mid();
    logic [3:0] any = '0;
    do_reset();
    bus.spawn = 4'b1111; cyc(); bus.spawn = '0;
    bus.tick = 1; repeat (25) cyc();
    checks++; if (bus.note_y !== 32'h32323232) begin errors++; $display("FAIL mid_y got %h want 32323232", bus.note_y); end
    reset = 1; cyc(); reset = 0; bus.tick = 0;
    checks++; if (bus.note_y !== 32'd0 || bus.note_active !== 4'd0 || bus.miss !== 4'd0) begin errors++; $display("FAIL mid_clear got %h/%b/%b want 0", bus.note_y, bus.note_active, bus.miss); end
    checks++; if (bus.lives !== 4'd3 || bus.score !== 8'd0) begin errors++; $display("FAIL mid_counters got %0d/%0d want 3/0", bus.lives, bus.score); end
    repeat (3) begin cyc(); any |= bus.miss; end
    checks++; if (any !== 4'd0) begin errors++; $display("FAIL mid_nomiss got %b want 0000", any); end
  endtask
  task automatic test_random();
    logic [31:0] yv;
    logic [3:0] av;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      reset = n % 700 == 0 || $urandom_range(0, 799) == 0;
      bus.tick = 1'($urandom_range(0, 1));
      for (int l = 0; l < 4; l++) begin
        bus.spawn[l] = $urandom_range(0, 19) == 0;
        if ($urandom_range(0, 9) == 0) bus.key_n[l] = ~bus.key_n[l];
      end
      cyc();
      for (int l = 0; l < 4; l++) begin yv[l*8 +: 8] = 8'(my[l]); av[l] = ma[l]; end
      checks++; if (bus.note_y !== yv || bus.note_active !== av) begin errors++; $display("FAIL rnd_lanes n=%0d got %h/%b want %h/%b", n, bus.note_y, bus.note_active, yv, av); end
      checks++; if ({bus.hit, bus.miss, bus.ghost} !== {mh, mm, mg}) begin errors++; $display("FAIL rnd_pulses n=%0d got %h want %h", n, {bus.hit, bus.miss, bus.ghost}, {mh, mm, mg}); end
      checks++; if (bus.score !== 8'(ms) || bus.streak !== 8'(mst)) begin errors++; $display("FAIL rnd_score n=%0d got %0d/%0d want %0d/%0d", n, bus.score, bus.streak, ms, mst); end
      checks++; if (bus2.score !== 2'(ms2) || bus2.streak !== 2'(mst2)) begin errors++; $display("FAIL rnd_score2 n=%0d got %0d/%0d want %0d/%0d", n, bus2.score, bus2.streak, ms2, mst2); end
      checks++; if (bus.lives !== 4'(ml) || bus.game_over !== mgo) begin errors++; $display("FAIL rnd_lives n=%0d got %0d/%0d want %0d/%0d", n, bus.lives, bus.game_over, ml, mgo); end
    end
    reset = 0;
  endtask
  initial begin
    reset = 1; bus.spawn = '0; bus.tick = 0; bus.key_n = '1;
    test_reset();
    test_hit();
    test_miss();
    test_ghost();
    test_double_hit();
    test_game_over();
    test_saturate();
    test_spawn_tick();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
